// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller.
// Contents: command encodings, FSM state encodings, mode constants and the
// prescaler divisor width (the divisor exists only when TIMER_PRESCALE_EN is defined).
package interval_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_SET_LIMIT = 2'b00,
    CMD_START     = 2'b01,
    CMD_STOP      = 2'b10,
    CMD_ACK       = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned DivBit = 8;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Command bus between the requesters and the interval timer controller.
// Signals: req (per-requester request), cmd (2 bits per requester, requester i at
// [2i+1:2i]), wdata (CntBit bits per requester, requester i at slice i) and gnt
// (one-hot grant, combinational). master = requester side, slave = timer side.
interface interval_timer_ctrl_if #(
  parameter int unsigned CntBit = 32,
  parameter int unsigned NumReq = 2
);
  logic [NumReq-1:0]        req;
  logic [2*NumReq-1:0]      cmd;
  logic [CntBit*NumReq-1:0] wdata;
  logic [NumReq-1:0]        gnt;

  modport master (output req, output cmd, output wdata, input gnt);
  modport slave  (input req, input cmd, input wdata, output gnt);
endinterface

// File: rtl/interval_timer_ctrl_rr_arbiter.sv
// Round-robin arbiter, reusable for any shared peripheral.
// Ports: clk, rst_n (async, active-low), req (request vector),
// gnt (one-hot grant, combinational from req and the internal pointer).
// The search starts at the pointer and ascends with wrap; after a grant to index k
// the pointer moves to (k+1) mod NumReq, and it holds when nothing is requested.
module interval_timer_ctrl_rr_arbiter #(
  parameter int unsigned NumReq = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      // Inner loop keeps every vector index a constant after unrolling.
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (j == idx && req[j] && !found) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          ptr_d  = PtrW'((j + 1 == NumReq) ? 0 : j + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller with a shared command bus.
// Ports: clk, rst_n (async, active-low), bus (slave side of interval_timer_ctrl_if:
// req/cmd/wdata in, gnt out), cnt (counter value), state (0 IDLE, 1 RUN, 2 DONE),
// expire (one-cycle pulse after an expiry), irq (level interrupt, cleared by ACK).
// Optional macro TIMER_PRESCALE_EN: START also loads an 8-bit divisor from
// wdata[8:1], and the counter ticks once every (div+1) clocks in RUN.
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int unsigned CntBit = 32,
  parameter int unsigned NumReq = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  interval_timer_ctrl_if.slave bus,
  output logic [CntBit-1:0]   cnt,
  output logic [1:0]          state,
  output logic                expire,
  output logic                irq
);

  logic [CntBit-1:0] cnt_q, limit_q, sel_wdata;
  logic [1:0]        sel_cmd;
  logic              mode_q, expire_q, irq_q, granted, tick, expiry;
  state_e            state_q;

  interval_timer_ctrl_rr_arbiter #(
    .NumReq(NumReq)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (bus.req),
    .gnt  (bus.gnt)
  );

  // gnt is one-hot, so OR-ing the masked slices selects the granted command.
  always_comb begin
    sel_cmd   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (bus.gnt[i]) begin
        sel_cmd   = sel_cmd | bus.cmd[2*i +: 2];
        sel_wdata = sel_wdata | bus.wdata[CntBit*i +: CntBit];
      end
    end
  end

  assign granted = |bus.gnt;

`ifdef TIMER_PRESCALE_EN
  logic [DivBit-1:0] div_q, psc_q;
  assign tick = (state_q == ST_RUN) && (psc_q == div_q);
`else
  assign tick = (state_q == ST_RUN);
`endif

  assign expiry = tick && (cnt_q == limit_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      limit_q  <= '0;
      mode_q   <= MODE_ONESHOT;
      state_q  <= ST_IDLE;
      expire_q <= 1'b0;
      irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      div_q    <= '0;
      psc_q    <= '0;
`endif
    end else begin
      expire_q <= expiry;

      // Expiry setting irq beats a same-cycle ACK.
      if (expiry) begin
        irq_q <= 1'b1;
      end else if (granted && sel_cmd == CMD_ACK) begin
        irq_q <= 1'b0;
      end

`ifdef TIMER_PRESCALE_EN
      // Every tick (and so every expiry) restarts the prescale count.
      if (tick) begin
        psc_q <= '0;
      end else if (state_q == ST_RUN) begin
        psc_q <= psc_q + 1'b1;
      end
`endif

      if (tick) begin
        if (expiry) begin
          if (mode_q == MODE_PERIODIC) begin
            cnt_q <= '0;
          end else begin
            state_q <= ST_DONE;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      // Later non-blocking writes win: START/STOP override the tick update above.
      if (granted) begin
        unique case (cmd_e'(sel_cmd))
          CMD_SET_LIMIT: limit_q <= sel_wdata;
          CMD_START: begin
            cnt_q   <= '0;
            mode_q  <= sel_wdata[0];
            state_q <= ST_RUN;
`ifdef TIMER_PRESCALE_EN
            div_q   <= sel_wdata[DivBit:1];
            psc_q   <= '0;
`endif
          end
          CMD_STOP: begin
            state_q <= ST_IDLE;
            cnt_q   <= cnt_q;
`ifdef TIMER_PRESCALE_EN
            psc_q   <= '0;
`endif
          end
          CMD_ACK: ;
          default: ;
        endcase
      end
    end
  end

  assign cnt    = cnt_q;
  assign state  = state_q;
  assign expire = expire_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed testbench for interval_timer_ctrl. A 32-bit instance carries most
// scenarios; a 10-bit instance makes the counter wrap reachable in a short run.
module tb_interval_timer_ctrl;
  import interval_timer_ctrl_pkg::*;

  localparam int unsigned SW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]   cnt;
  logic [1:0]    state;
  logic          expire, irq;
  logic [SW-1:0] cnt8;
  logic [1:0]    state8;
  logic          expire8, irq8;

  interval_timer_ctrl_if #(.CntBit(32), .NumReq(2)) bus ();
  interval_timer_ctrl_if #(.CntBit(SW), .NumReq(2)) bus8 ();

  interval_timer_ctrl #(.CntBit(32), .NumReq(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .cnt   (cnt),
    .state (state),
    .expire(expire),
    .irq   (irq)
  );

  interval_timer_ctrl #(.CntBit(SW), .NumReq(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .cnt   (cnt8),
    .state (state8),
    .expire(expire8),
    .irq   (irq8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until granted, let it execute on that edge, then drop it.
  task automatic issue(input int idx, input logic [1:0] c, input logic [31:0] d);
    bus.req[idx] = 1'b1;
    bus.cmd[2*idx +: 2] = c;
    bus.wdata[32*idx +: 32] = d;
    #1;
    for (int i = 0; i < 20 && bus.gnt[idx] !== 1'b1; i++) step();
    checks++;
    if (bus.gnt !== (2'b01 << idx)) begin
      errors++;
      $display("FAIL issue_gnt: got %b expected %b", bus.gnt, 2'b01 << idx);
    end
    step();
    bus.req[idx] = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] c, input logic [SW-1:0] d);
    bus8.req[0] = 1'b1;
    bus8.cmd[1:0] = c;
    bus8.wdata[SW-1:0] = d;
    #1;
    for (int i = 0; i < 20 && bus8.gnt[0] !== 1'b1; i++) step();
    checks++;
    if (bus8.gnt !== 2'b01) begin
      errors++;
      $display("FAIL issue8_gnt: got %b expected 01", bus8.gnt);
    end
    step();
    bus8.req[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;  bus.cmd = '0;  bus.wdata = '0;
    bus8.req = '0; bus8.cmd = '0; bus8.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (expire !== 1'b0) begin errors++; $display("FAIL reset_expire: got %b expected 0", expire); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
  endtask

  task automatic test_oneshot();
    issue(0, CMD_SET_LIMIT, 32'd3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL os_setlim_state: got %0d expected 0", state); end
    issue(0, CMD_START, 32'd0);
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL os_start_cnt: got %0d expected 0", cnt); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL os_start_state: got %0d expected 1", state); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (cnt !== 32'(k)) begin errors++; $display("FAIL os_cnt: got %0d expected %0d", cnt, k); end
      checks++; if (expire !== 1'b0) begin errors++; $display("FAIL os_early_expire: got %b expected 0", expire); end
    end
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL os_done_state: got %0d expected 2", state); end
    checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL os_done_cnt: got %0d expected 3", cnt); end
    checks++; if (expire !== 1'b1) begin errors++; $display("FAIL os_expire: got %b expected 1", expire); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq: got %b expected 1", irq); end
    step();
    checks++; if (expire !== 1'b0) begin errors++; $display("FAIL os_expire_once: got %b expected 0", expire); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq_held: got %b expected 1", irq); end
    issue(0, CMD_ACK, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_ack_irq: got %b expected 0", irq); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL os_ack_state: got %0d expected 2", state); end
  endtask

  task automatic test_periodic();
    issue(0, CMD_SET_LIMIT, 32'd2);
    issue(0, CMD_START, 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      checks++; if (cnt !== 32'(k % 3)) begin errors++; $display("FAIL per_cnt: got %0d expected %0d", cnt, k % 3); end
      checks++; if (expire !== (k > 0 && k % 3 == 0)) begin errors++; $display("FAIL per_expire: got %b at k=%0d", expire, k); end
      checks++; if (irq !== (k >= 3)) begin errors++; $display("FAIL per_irq: got %b at k=%0d", irq, k); end
    end
  endtask

  // Pointer sits at 1 after the grants to requester 0, so requester 1 wins first.
  task automatic test_back_to_back();
    logic [1:0] exp_g;
    bus.req = 2'b11;
    bus.cmd = {CMD_START, CMD_STOP};
    bus.wdata = {32'd1, 32'd0};
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL b2b_gnt: got %b expected %b", bus.gnt, exp_g); end
      step();
      checks++;
      if (state !== ((exp_g == 2'b10) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL b2b_state: got %0d at k=%0d", state, k);
      end
      checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL b2b_cnt: got %0d expected 0", cnt); end
    end
    bus.req = 2'b00;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL b2b_idle_gnt: got %b expected 00", bus.gnt); end
    step();
  endtask

  task automatic test_ack_on_expiry();
    issue(1, CMD_ACK, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ae_pre_ack: got %b expected 0", irq); end
    issue(1, CMD_SET_LIMIT, 32'd1);
    issue(0, CMD_START, 32'd1);
    step();
    checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL ae_cnt: got %0d expected 1", cnt); end
    issue(1, CMD_ACK, 32'd0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ae_irq_wins: got %b expected 1", irq); end
    checks++; if (expire !== 1'b1) begin errors++; $display("FAIL ae_expire: got %b expected 1", expire); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL ae_wrap_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_wrap();
    int pulses;
    issue8(CMD_SET_LIMIT, SW'(1000));
    issue8(CMD_START, SW'(0));
    repeat (5) step();
    checks++; if (cnt8 !== SW'(5)) begin errors++; $display("FAIL wrap_cnt5: got %0d expected 5", cnt8); end
    issue8(CMD_SET_LIMIT, SW'(2));
    checks++; if (cnt8 !== SW'(6)) begin errors++; $display("FAIL wrap_cnt6: got %0d expected 6", cnt8); end
    pulses = 0;
    for (int n = 0; n < (1 << SW) - 1 - 6; n++) begin
      step();
      if (expire8 === 1'b1) pulses++;
    end
    checks++; if (cnt8 !== SW'((1 << SW) - 1)) begin errors++; $display("FAIL wrap_max: got %0d expected %0d", cnt8, (1 << SW) - 1); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL wrap_early: got %0d pulses expected 0", pulses); end
    step();
    checks++; if (cnt8 !== SW'(0)) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", cnt8); end
    checks++; if (expire8 !== 1'b0) begin errors++; $display("FAIL wrap_silent: got %b expected 0", expire8); end
    repeat (2) step();
    checks++; if (state8 !== 2'd1) begin errors++; $display("FAIL wrap_run: got %0d expected 1", state8); end
    step();
    checks++; if (state8 !== 2'd2) begin errors++; $display("FAIL wrap_done: got %0d expected 2", state8); end
    checks++; if (cnt8 !== SW'(2)) begin errors++; $display("FAIL wrap_hold: got %0d expected 2", cnt8); end
    checks++; if (expire8 !== 1'b1) begin errors++; $display("FAIL wrap_expire: got %b expected 1", expire8); end
  endtask

  task automatic test_async_reset();
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ar_pre_state: got %0d expected 1", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", cnt); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state: got %0d expected 0", state); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq: got %b expected 0", irq); end
    checks++; if (expire !== 1'b0) begin errors++; $display("FAIL ar_expire: got %b expected 0", expire); end
    checks++; if (state8 !== 2'd0) begin errors++; $display("FAIL ar_state8: got %0d expected 0", state8); end
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL ar_irq8: got %b expected 0", irq8); end
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL ar_post_cnt: got %0d expected 0", cnt); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL ar_post_gnt: got %b expected 00", bus.gnt); end
  endtask

  // START with wdata = {div=3, periodic}; without the prescaler the divisor is ignored.
  task automatic test_prescale();
    int exp_cnt;
    logic exp_exp;
    issue(0, CMD_SET_LIMIT, 32'd1);
    issue(0, CMD_START, 32'd7);
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef TIMER_PRESCALE_EN
      exp_cnt = (k / 4) % 2;
      exp_exp = (k % 8 == 0);
`else
      exp_cnt = k % 2;
      exp_exp = (k % 2 == 0);
`endif
      checks++; if (cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL psc_cnt: got %0d expected %0d k=%0d", cnt, exp_cnt, k); end
      checks++; if (expire !== exp_exp) begin errors++; $display("FAIL psc_expire: got %b expected %b k=%0d", expire, exp_exp, k); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_back_to_back();
    test_ack_on_expiry();
    test_wrap();
    test_async_reset();
    test_prescale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Programmable interval-timer controller that sequences an embedded synchronous up-counter (enable/load/value style) through one-shot and periodic expiries.
- Shares the counter between NumReq command requesters via a round-robin arbiter.
- Raises a level interrupt on expiry.
- Sits beside the CPU core as the timer peripheral; requesters are the core's memory-mapped write path and the debug port.

Parameters:
CntBit, 32, counter and limit width
NumReq, 2, number of command requesters (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset: asynchronous, active-low
req  input  NumReq  per-requester command request
cmd  input  2*NumReq  per-requester command; requester i owns bits [2i+1:2i]
wdata  input  CntBit*NumReq  per-requester operand; requester i owns slice i
gnt  output  NumReq  one-hot grant, combinational
cnt  output  CntBit  current counter value
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 DONE
expire  output  1  one-cycle pulse on expiry
irq  output  1  interrupt pending, level

Behaviour:
- Reset values: cnt=0, limit=0, mode=one-shot, state=IDLE, irq=0, expire=0, RR pointer=0, gnt=0.
- Arbiter:
  - gnt is one-hot among asserted req bits.
  - Search starts at the RR pointer, ascending with wrap.
  - Granted command executes at the clock edge where gnt is high.
  - After a grant to index k, the pointer becomes (k+1) mod NumReq.
  - No req: gnt=0 and the pointer holds.
  - Requester holds req/cmd/wdata until it sees gnt.
  - One command per cycle.
- Commands:
  - 00 SET_LIMIT: limit <= wdata. State and cnt unchanged; a new limit applies from the next compare.
  - 01 START: cnt <= 0; mode <= wdata[0] (0 one-shot, 1 periodic); state <= RUN. Legal in any state; restarts a running timer.
  - 10 STOP: state <= IDLE; cnt holds.
  - 11 ACK: irq <= 0.
- FSM:
  - IDLE: counter disabled.
  - RUN: cnt increments on every tick. Expiry is when a tick occurs with cnt==limit:
    - periodic: cnt <= 0, stay in RUN;
    - one-shot: state <= DONE, cnt holds at limit.
    - On expiry, expire pulses for the following cycle and irq <= 1.
  - DONE: counter disabled; only START leaves it (STOP goes to IDLE).
- Compare uses equality only. A limit written below the current cnt causes cnt to wrap through 2^CntBit-1 to 0 before matching. Natural wrap is silent.
- limit=0 in periodic mode: expiry on every tick, cnt stays 0.
- Simultaneous events:
  - A granted command overrides the expiry's cnt/state update.
  - Expiry's irq set wins over a same-cycle ACK (irq stays 1).
  - expire still pulses.
- Reset mid-operation: all state returns to reset values immediately (async); no pending command survives.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - START additionally loads an 8-bit divisor from wdata[8:1] and clears the prescaler.
  - A tick occurs once every (div+1) clocks while in RUN; div=0 gives a tick every clock.
  - The prescaler is cleared on STOP, on reset and on every expiry.
- Not defined:
  - Tick = every clock in RUN.
  - wdata[8:1] is ignored; no prescaler register exists.

Decomposition:
- Shared package:
  - command encodings (CMD_SET_LIMIT, CMD_START, CMD_STOP, CMD_ACK);
  - state encodings (ST_IDLE, ST_RUN, ST_DONE);
  - mode bit constants.
- Natural sub-module: rr_arbiter (parameter NumReq; req in, gnt out, pointer update on grant), reusable for other shared peripherals.
- The counter register with enable/load stays inline or reuses the team's existing counter block.

Test Plan:
- Reset, then requester 0 SET_LIMIT 3, START one-shot → cnt 0,1,2,3 on successive cycles; expire pulses once; state=DONE with cnt=3; irq=1 until ACK; ACK → irq=0.
- limit=2, START periodic → cnt sequence 0,1,2,0,1,2…; expire pulses every 3 cycles; irq stays 1 without ACK.
- Both requesters hold req continuously (req0=STOP, req1=START periodic) → gnt alternates 01,10,01…; each command takes effect on its granted edge.
- Periodic limit=1 with ACK issued on the expiry cycle → irq remains 1; expire=1 next cycle.
- Running with cnt=5, SET_LIMIT 2 → cnt continues to 2^32-1, wraps to 0, expires at 2; then rst_n low mid-run → all outputs zero asynchronously.
- With TIMER_PRESCALE_EN: START periodic with div=3, limit=1 → cnt changes every 4 clocks; expire every 8 clocks.
